// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - register map, control words and host FSM states for the interval timer slave
package timer_regs_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    localparam logic [3:0] CTRL_RUN  = 4'h7;
    localparam logic [3:0] CTRL_STOP = 4'h8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_PL     = 4'd1,
        ST_WR_PH     = 4'd2,
        ST_WR_CTL    = 4'd3,
        ST_RUN       = 4'd4,
        ST_CLR_TO    = 4'd5,
        ST_WR_STOP   = 4'd6,
        ST_CLR_STOP  = 4'd7,
        ST_SNAP_L    = 4'd8,
        ST_SNAP_RL   = 4'd9,
        ST_SNAP_RH   = 4'd10,
        ST_SNAP_DONE = 4'd11
    } state_t;

endpackage

// File: rtl/avmm_timer_bus_drv.sv
// rtl/avmm_timer_bus_drv.sv - combinational decode of host FSM state into Avalon-MM bus signals
module avmm_timer_bus_drv
    import timer_regs_pkg::*;
#(
    parameter logic [3:0] RUN_WORD  = 4'h7,
    parameter logic [3:0] STOP_WORD = 4'h8
) (
    input  state_t      state_i,
    input  logic [31:0] period_i,
    output logic [2:0]  av_address_o,
    output logic        av_chipselect_o,
    output logic        av_write_n_o,
    output logic [15:0] av_writedata_o
);

    always_comb begin
        av_address_o    = 3'd0;
        av_chipselect_o = 1'b0;
        av_write_n_o    = 1'b1;
        av_writedata_o  = 16'h0000;
        case (state_i)
            ST_WR_PL: begin
                av_address_o    = REG_PERIOD_L;
                av_chipselect_o = 1'b1;
                av_write_n_o    = 1'b0;
                av_writedata_o  = period_i[15:0];
            end
            ST_WR_PH: begin
                av_address_o    = REG_PERIOD_H;
                av_chipselect_o = 1'b1;
                av_write_n_o    = 1'b0;
                av_writedata_o  = period_i[31:16];
            end
            ST_WR_CTL: begin
                av_address_o    = REG_CONTROL;
                av_chipselect_o = 1'b1;
                av_write_n_o    = 1'b0;
                av_writedata_o  = {12'h000, RUN_WORD};
            end
            ST_WR_STOP: begin
                av_address_o    = REG_CONTROL;
                av_chipselect_o = 1'b1;
                av_write_n_o    = 1'b0;
                av_writedata_o  = {12'h000, STOP_WORD};
            end
            // Writing status clears the slave's timeout flag.
            ST_CLR_TO, ST_CLR_STOP: begin
                av_address_o    = REG_STATUS;
                av_chipselect_o = 1'b1;
                av_write_n_o    = 1'b0;
            end
            ST_SNAP_L: begin
                av_address_o    = REG_SNAP_L;
                av_chipselect_o = 1'b1;
                av_write_n_o    = 1'b0;
            end
            ST_SNAP_RL: begin
                av_address_o    = REG_SNAP_L;
                av_chipselect_o = 1'b1;
            end
            ST_SNAP_RH: begin
                av_address_o    = REG_SNAP_H;
                av_chipselect_o = 1'b1;
            end
            default: begin
                av_address_o    = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/interval_timer_host.sv
// rtl/interval_timer_host.sv - hardware Avalon-MM master that runs the interval timer and counts its timeouts
module interval_timer_host
    import timer_regs_pkg::*;
#(
    parameter int          COUNT_W        = 8,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h005F5E0F,
    parameter logic [3:0]  RUN_CTRL_WORD  = 4'h7,
    parameter logic [3:0]  STOP_CTRL_WORD = 4'h8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               snap_req,
    input  logic [31:0]        period_in,
    input  logic               irq,
    output logic [2:0]         av_address,
    output logic               av_chipselect,
    output logic               av_write_n,
    output logic [15:0]        av_writedata,
    input  logic [15:0]        av_readdata,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               busy,
    output logic [31:0]        snap_value,
    output logic               snap_valid
);

    state_t               state_q, state_d;
    logic [31:0]          period_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 running_q;
    logic [31:0]          snap_value_q;
    logic                 snap_valid_q;
    logic                 start_accept;

    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_WR_PL;
                    start_accept = 1'b1;
                end else if (snap_req) begin
                    state_d = ST_SNAP_L;
                end
            end
            ST_WR_PL:  state_d = ST_WR_PH;
            ST_WR_PH:  state_d = ST_WR_CTL;
            ST_WR_CTL: state_d = ST_RUN;
            // A level irq that arrived during a sequence is serviced first here.
            ST_RUN: begin
                if (irq) begin
                    state_d = ST_CLR_TO;
                end else if (stop) begin
                    state_d = ST_WR_STOP;
                end else if (start) begin
                    state_d      = ST_WR_PL;
                    start_accept = 1'b1;
                end else if (snap_req) begin
                    state_d = ST_SNAP_L;
                end
            end
            ST_CLR_TO:    state_d = ST_RUN;
            ST_WR_STOP:   state_d = ST_CLR_STOP;
            ST_CLR_STOP:  state_d = ST_IDLE;
            ST_SNAP_L:    state_d = ST_SNAP_RL;
            ST_SNAP_RL:   state_d = ST_SNAP_RH;
            ST_SNAP_RH:   state_d = ST_SNAP_DONE;
            ST_SNAP_DONE: state_d = running_q ? ST_RUN : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            period_q     <= 32'h0;
            count_q      <= '0;
            running_q    <= 1'b0;
            snap_value_q <= 32'h0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_valid_q <= (state_q == ST_SNAP_DONE);
            if (start_accept) begin
                period_q <= (period_in == 32'h0) ? DEFAULT_PERIOD : period_in;
                count_q  <= '0;
            end
            if (state_q == ST_CLR_TO) begin
                count_q <= count_q + 1'b1;
            end
            if (state_q == ST_WR_CTL) begin
                running_q <= 1'b1;
            end
            if (state_q == ST_WR_STOP) begin
                running_q <= 1'b0;
            end
            // Slave readdata lags the address by one cycle.
            if (state_q == ST_SNAP_RH) begin
                snap_value_q[15:0] <= av_readdata;
            end
            if (state_q == ST_SNAP_DONE) begin
                snap_value_q[31:16] <= av_readdata;
            end
        end
    end

    avmm_timer_bus_drv #(
        .RUN_WORD  (RUN_CTRL_WORD),
        .STOP_WORD (STOP_CTRL_WORD)
    ) u_bus_drv (
        .state_i         (state_q),
        .period_i        (period_q),
        .av_address_o    (av_address),
        .av_chipselect_o (av_chipselect),
        .av_write_n_o    (av_write_n),
        .av_writedata_o  (av_writedata)
    );

    assign count      = count_q;
    assign running    = running_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_interval_timer_host.sv
// tb/tb_interval_timer_host.sv - self-checking bench for interval_timer_host with a behavioural timer slave
module tb_interval_timer_host;

    localparam int          CW         = 4;
    localparam logic [31:0] DEF_PERIOD = 32'h005F5E0F;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          snap_req = 1'b0;
    logic [31:0]   period_in = 32'h0;
    logic          irq;
    logic [2:0]    av_address;
    logic          av_chipselect;
    logic          av_write_n;
    logic [15:0]   av_writedata;
    logic [15:0]   av_readdata;
    logic [CW-1:0] count;
    logic          running;
    logic          busy;
    logic [31:0]   snap_value;
    logic          snap_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idle_bad = 0;
    int model_count = 0;
    logic model_running = 1'b0;

    logic [19:0] bus_log[$];
    logic [19:0] exp_log[$];
    int          bus_cyc[$];

    logic        raise_to = 1'b0;
    logic [31:0] slave_cnt = 32'h0;
    logic        to_q, ito_q;
    logic [31:0] snap_q;

    always #5 clk = ~clk;

    interval_timer_host #(.COUNT_W(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .snap_req      (snap_req),
        .period_in     (period_in),
        .irq           (irq),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .count         (count),
        .running       (running),
        .busy          (busy),
        .snap_value    (snap_value),
        .snap_valid    (snap_valid)
    );

    // Timer slave: timeout flag raised on bench request, cleared by a status write.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q        <= 1'b0;
            ito_q       <= 1'b0;
            snap_q      <= 32'h0;
            av_readdata <= 16'h0;
        end else begin
            if (raise_to) to_q <= 1'b1;
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: to_q <= 1'b0;
                    3'd1: ito_q <= av_writedata[0];
                    3'd4: snap_q <= slave_cnt;
                    default: ;
                endcase
            end
            if (av_chipselect && av_write_n && av_address == 3'd4) av_readdata <= snap_q[15:0];
            else if (av_chipselect && av_write_n && av_address == 3'd5) av_readdata <= snap_q[31:16];
            else av_readdata <= 16'h0;
        end
    end
    assign irq = to_q & ito_q;

    always @(negedge clk) begin
        cyc++;
        if (av_chipselect) begin
            bus_log.push_back({~av_write_n, av_address, av_writedata});
            bus_cyc.push_back(cyc);
        end else if (av_write_n !== 1'b1 || av_address !== 3'd0 || av_writedata !== 16'h0) begin
            idle_bad++;
        end
    end

    function automatic logic [19:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [19:0] rd(input logic [2:0] a);
        return {1'b0, a, 16'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        bus_log.delete();
        bus_cyc.delete();
        exp_log.delete();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, bus_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
            check($sformatf("%s_txn%0d", tag, i), {12'h0, bus_log[i]}, {12'h0, exp_log[i]});
    endtask

    task automatic do_start(input logic [31:0] p);
        logic [31:0] eff;
        int n;
        eff = (p == 32'h0) ? DEF_PERIOD : p;
        clear_logs();
        exp_log.push_back(wr(3'd2, eff[15:0]));
        exp_log.push_back(wr(3'd3, eff[31:16]));
        exp_log.push_back(wr(3'd1, 16'h0007));
        period_in = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            n++;
            @(negedge clk);
        end
        model_count   = 0;
        model_running = 1'b1;
        check("prog_busy_cycles", n, 3);
        check("prog_running", running, model_running);
        check("prog_count", count, model_count);
        check_log("prog");
        if (bus_cyc.size() == 3) check("prog_consecutive", bus_cyc[2] - bus_cyc[0], 2);
    endtask

    task automatic do_irqs(input int n);
        clear_logs();
        for (int i = 0; i < n; i++) begin
            raise_to = 1'b1;
            @(negedge clk);
            raise_to = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("irq_low_after_clear", irq, 1'b0);
            exp_log.push_back(wr(3'd0, 16'h0));
            model_count = (model_count + 1) % (1 << CW);
        end
        check("irq_count", count, model_count);
        check("irq_running", running, model_running);
        check_log("irq");
    endtask

    task automatic do_snap(input logic [31:0] v);
        int first;
        int pulses;
        logic [31:0] seen;
        first  = -1;
        pulses = 0;
        seen   = 32'h0;
        clear_logs();
        exp_log.push_back(wr(3'd4, 16'h0));
        exp_log.push_back(rd(3'd4));
        exp_log.push_back(rd(3'd5));
        slave_cnt = v;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (snap_valid) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    seen  = snap_value;
                end
            end
            @(negedge clk);
        end
        check("snap_latency", first, 4);
        check("snap_pulses", pulses, 1);
        check("snap_value", seen, v);
        check("snap_running", running, model_running);
        check("snap_count", count, model_count);
        check_log("snap");
    endtask

    initial begin
        logic [31:0] p;

        #12;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_busy", busy, 0);
        check("rst_cs", av_chipselect, 0);
        check("rst_write_n", av_write_n, 1);
        check("rst_snap_valid", snap_valid, 0);
        check("rst_snap_value", snap_value, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        clear_logs();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_stop_busy", busy, 0);
        check_log("idle_stop");

        do_start(32'h0001_0004);
        do_irqs(5);
        check("five_irqs", count, 5);
        do_irqs(12);
        check("wrap_17", count, 1);

        do_snap(32'h0012_3456);

        // irq and stop together: the timeout wins and the stop pulse is lost.
        clear_logs();
        raise_to = 1'b1;
        @(negedge clk);
        raise_to = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        model_count = (model_count + 1) % (1 << CW);
        exp_log.push_back(wr(3'd0, 16'h0));
        check("irqstop_count", count, model_count);
        check("irqstop_running", running, 1);
        check_log("irqstop");

        clear_logs();
        exp_log.push_back(wr(3'd1, 16'h0008));
        exp_log.push_back(wr(3'd0, 16'h0));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        model_running = 1'b0;
        check("stop_running", running, 0);
        check("stop_busy", busy, 0);
        check("stop_count", count, model_count);
        check_log("stop");

        do_start(32'h0);
        do_irqs(2);

        p = $urandom;
        period_in = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        check("midrst_pre_addr", av_address, 3);
        check("midrst_pre_cs", av_chipselect, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_cs", av_chipselect, 0);
        check("midrst_write_n", av_write_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        check("midrst_running", running, 0);
        check("midrst_snap_value", snap_value, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_count   = 0;
        model_running = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            p = $urandom;
            if (r == 1) p = 32'h0;
            do_start(p);
            do_irqs($urandom_range(1, 20));
            do_snap($urandom);
        end

        check("idle_bus_values", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_host.md
Name: interval_timer_host

Overview:
- Avalon-MM master that drives the 16-bit-data interval timer slave (6 registers: status, control, period_l, period_h, snap_l, snap_h) from hardware, with no CPU involved.
- Programs the period, starts the timer in continuous mode with interrupt enabled, and services each irq by clearing the timeout and incrementing a binary count.
- Supports stop, and snapshot read-back of the live counter.
- Sits between the timer slave and the LED/count logic of the count_binary system.

Parameters:
- COUNT_W, 8, width of tick counter output.
- DEFAULT_PERIOD, 32'h005F5E0F, period substituted when period_in == 0.
- CTRL_RUN, 4'h7, control word for start: START=1, CONT=1, ITO=1.
- CTRL_STOP, 4'h8, control word for stop: STOP=1, all other bits 0.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request: program period_in and run
- stop  in  1  one-cycle request: stop the timer
- snap_req  in  1  one-cycle request: capture and read the live timer count
- period_in  in  32  period (timer ticks minus one), sampled on accepted start
- irq  in  1  timer interrupt, level
- av_address  out  3  slave register index
- av_chipselect  out  1  bus select
- av_write_n  out  1  0 = write
- av_writedata  out  16  write data
- av_readdata  in  16  slave readdata, registered, valid one cycle after address
- count  out  COUNT_W  number of serviced timeouts
- running  out  1  timer started and not stopped
- busy  out  1  FSM not in IDLE or RUN
- snap_value  out  32  last snapshot
- snap_valid  out  1  one-cycle pulse when snap_value updates

Behaviour:
- Reset values: all outputs 0, except av_write_n = 1. FSM enters IDLE. Reset is honoured mid-sequence; a partial bus transaction is abandoned.
- Idle bus (any cycle without a transaction): chipselect=0, write_n=1, address=0, writedata=0.
- The slave has no waitrequest, so every write takes exactly one cycle: chipselect=1, write_n=0.
- Reads: chipselect=1, write_n=1. av_readdata is captured on the following cycle, and address reads are pipelined back-to-back.
- FSM states:
  - IDLE: start → WR_PL. snap_req → SNAP_L. stop is ignored.
  - WR_PL: writes addr 2 with period[15:0].
  - WR_PH: writes addr 3 with period[31:16].
  - WR_CTL: writes addr 1 with {12'b0, CTRL_RUN}. Sets running=1 → RUN.
  - RUN: priority irq > stop > start > snap_req.
    - irq → CLR_TO.
    - stop → WR_STOP.
    - start → WR_PL (re-program; the period write already forces the timer to stop and reload).
    - snap_req → SNAP_L.
  - CLR_TO: writes addr 0 (data 0). count <= count + 1, wrapping from 2^COUNT_W-1 to 0 → RUN. The slave clears its timeout on this edge, so irq is low in the next RUN cycle. Each timeout is counted exactly once.
  - WR_STOP: writes addr 1 with {12'b0, CTRL_STOP}. running <= 0 → CLR_STOP.
  - CLR_STOP: writes addr 0 to discard a stale timeout. count is NOT incremented → IDLE.
  - SNAP_L: writes addr 4, which latches the slave snapshot.
  - SNAP_RL: reads addr 4.
  - SNAP_RH: reads addr 5; captures readdata → snap_value[15:0].
  - SNAP_DONE: captures readdata → snap_value[31:16]; pulses snap_valid; returns to RUN if running, else IDLE.
- Period latch: a period register latches on the accepted start (IDLE or RUN). Value is period_in, or DEFAULT_PERIOD if period_in == 0.
- count clears to 0 on an accepted start.
- Requests are accepted only in IDLE/RUN per the priorities above. Requests arriving while busy=1 are dropped, not queued.
- An irq arriving during a snapshot or programming sequence stays asserted (level) and is serviced on return to RUN.

Decomposition:
- Shared package timer_regs_pkg holds:
  - register address constants: STATUS=0, CONTROL=1, PERIOD_L=2, PERIOD_H=3, SNAP_L=4, SNAP_H=5
  - control bit positions: ITO=0, CONT=1, START=2, STOP=3
  - CTRL_RUN / CTRL_STOP
  - FSM state enum
- One natural sub-module: avmm_timer_bus_drv. It is a combinational decode of the state into address, chipselect, write_n and writedata. Everything else stays flat.

Test Plan:
- Reset, then start with period_in=32'h0001_0004 → writes seen in order: addr2=0x0004, addr3=0x0001, addr1=0x0007 on three consecutive cycles; running=1; busy high for 3 cycles.
- Slave model raises irq 5 times, clearing it on a status write → exactly five addr0 writes, count=5, irq low on the cycle after each clear.
- COUNT_W=4 with 17 irqs → count wraps to 1.
- snap_req in RUN with slave counter snapshot 0x0012_3456 → write addr4, reads addr4 then addr5; snap_value=0x00123456; single snap_valid pulse 4 cycles after request.
- irq and stop asserted in the same RUN cycle → CLR_TO first (count+1), then stop is dropped since it is a single-cycle request. Separate stop → addr1=0x0008, addr0 write, running=0, count unchanged, state IDLE.
- start with period_in=0 → addr2=0x5E0F, addr3=0x005F. reset_n low mid-WR_PH → bus idles immediately; count=0, running=0.
